// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
// riscv_ctrl_pkg: shared encodings for the RV32I multicycle main control.
// Revision: 1.0
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] ST_FETCH     = 4'd0;
    localparam logic [3:0] ST_DECODE    = 4'd1;
    localparam logic [3:0] ST_EXEC_R    = 4'd2;
    localparam logic [3:0] ST_EXEC_I    = 4'd3;
    localparam logic [3:0] ST_MEM_ADDR  = 4'd4;
    localparam logic [3:0] ST_MEM_READ  = 4'd5;
    localparam logic [3:0] ST_MEM_WB    = 4'd6;
    localparam logic [3:0] ST_MEM_WRITE = 4'd7;
    localparam logic [3:0] ST_ALU_WB    = 4'd8;
    localparam logic [3:0] ST_BRANCH    = 4'd9;
    localparam logic [3:0] ST_JAL       = 4'd10;
    localparam logic [3:0] ST_TRAP      = 4'd11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

`default_nettype wire

// File: rtl/ctrl_state_decode.sv
// ============================================================================
// ctrl_state_decode: combinational Moore decode of the control state, with
// mem_ready gating in FETCH/MEM_WRITE and branch-taken gating of pc_write.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ctrl_state_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       mem_ready_i,
    input  logic       zero_i,
    input  logic       branch_inv_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       i_or_d_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       pc_src_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] result_src_o,
    output logic       instr_retired_o,
    output logic       illegal_instr_o
);

    always_comb begin
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        i_or_d_o        = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_src_o        = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = SRCA_PC;
        alu_src_b_o     = SRCB_REG;
        alu_op_o        = ALUOP_ADD;
        result_src_o    = RES_ALUOUT;
        instr_retired_o = 1'b0;
        illegal_instr_o = 1'b0;
        case (state_i)
            ST_FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            ST_DECODE: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_IMM;
            end
            ST_EXEC_R: begin
                alu_src_a_o = SRCA_REG;
                alu_src_b_o = SRCB_REG;
                alu_op_o    = ALUOP_FUNCT;
            end
            ST_EXEC_I: begin
                alu_src_a_o = SRCA_REG;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALUOP_FUNCT;
            end
            ST_MEM_ADDR: begin
                alu_src_a_o = SRCA_REG;
                alu_src_b_o = SRCB_IMM;
            end
            ST_MEM_READ: begin
                mem_req_o = 1'b1;
                i_or_d_o  = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write_o     = 1'b1;
                result_src_o    = RES_MDR;
                instr_retired_o = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_req_o       = 1'b1;
                mem_we_o        = 1'b1;
                i_or_d_o        = 1'b1;
                instr_retired_o = mem_ready_i;
            end
            ST_ALU_WB: begin
                reg_write_o     = 1'b1;
                instr_retired_o = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a_o     = SRCA_REG;
                alu_src_b_o     = SRCB_REG;
                alu_op_o        = ALUOP_SUB;
                pc_src_o        = 1'b1;
                // BEQ takes on zero, BNE (funct3[0]=1) on not-zero
                pc_write_o      = zero_i ^ branch_inv_i;
                instr_retired_o = 1'b1;
            end
            ST_JAL: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_FOUR;
                pc_src_o    = 1'b1;
                pc_write_o  = 1'b1;
            end
            ST_TRAP: begin
                illegal_instr_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control: RV32I multicycle main control FSM (state register and
// next-state logic; output decode lives in ctrl_state_decode).
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter bit         TRAP_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       instr_retired,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] w_dec_state;
    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_reg_write;
    logic       w_instr_retired;
    logic       w_illegal_instr;
    logic       w_unused_funct3;

    assign w_unused_funct3 = ^funct3[2:1];

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:     state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_R:               state_d = ST_EXEC_R;
                    OP_I:               state_d = ST_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = ST_MEM_ADDR;
                    OP_BRANCH:          state_d = ST_BRANCH;
                    OP_JAL:             state_d = ST_JAL;
                    default:            state_d = ST_TRAP;
                endcase
            end
            ST_EXEC_R:    state_d = ST_ALU_WB;
            ST_EXEC_I:    state_d = ST_ALU_WB;
            ST_MEM_ADDR:  state_d = (opcode == OP_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  state_d = mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_MEM_WRITE: state_d = mem_ready ? ST_FETCH : ST_MEM_WRITE;
            ST_ALU_WB:    state_d = ST_FETCH;
            ST_BRANCH:    state_d = ST_FETCH;
            ST_JAL:       state_d = ST_ALU_WB;
            ST_TRAP:      state_d = TRAP_STICKY ? ST_TRAP : ST_FETCH;
            default:      state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // During reset the muxes show FETCH values and every enable is masked
    assign w_dec_state = rst ? ST_FETCH : state_q;

    ctrl_state_decode u_decode (
        .state_i         (w_dec_state),
        .mem_ready_i     (mem_ready),
        .zero_i          (zero),
        .branch_inv_i    (funct3[0]),
        .mem_req_o       (w_mem_req),
        .mem_we_o        (w_mem_we),
        .i_or_d_o        (i_or_d),
        .ir_write_o      (w_ir_write),
        .pc_write_o      (w_pc_write),
        .pc_src_o        (pc_src),
        .reg_write_o     (w_reg_write),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .alu_op_o        (alu_op),
        .result_src_o    (result_src),
        .instr_retired_o (w_instr_retired),
        .illegal_instr_o (w_illegal_instr)
    );

    assign mem_req       = w_mem_req       & ~rst;
    assign mem_we        = w_mem_we        & ~rst;
    assign ir_write      = w_ir_write      & ~rst;
    assign pc_write      = w_pc_write      & ~rst;
    assign reg_write     = w_reg_write     & ~rst;
    assign instr_retired = w_instr_retired & ~rst;
    assign illegal_instr = w_illegal_instr & ~rst;
    assign state_dbg     = rst ? 4'd0 : state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control: directed vectors for the multicycle control FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       instr_retired;
    logic       illegal_instr;
    logic [3:0] state_dbg;

    int n_checks;
    int n_pass;

    multicycle_control #(
        .RESET_STATE (4'd0),
        .TRAP_STICKY (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .funct3        (funct3),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .result_src    (result_src),
        .instr_retired (instr_retired),
        .illegal_instr (illegal_instr),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change here, checks follow #1 later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        opcode    = 7'b0110011;
        funct3    = 3'b000;
        zero      = 1'b0;
        mem_ready = 1'b0;

        // Reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            chk("rst_state", state_dbg, 4'd0);
            chk("rst_mem_req", mem_req, 1'b0);
            chk("rst_enables", {mem_we, ir_write, pc_write, reg_write, instr_retired, illegal_instr}, 6'b0);
            chk("rst_srcb", alu_src_b, 2'b10);
        end

        // R-type ADD, mem_ready tied high: 0,1,2,8
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("r_fetch_state", state_dbg, 4'd0);
        chk("r_fetch_mem_req", mem_req, 1'b1);
        chk("r_fetch_srcb", alu_src_b, 2'b10);
        chk("r_fetch_irw_pcw", {ir_write, pc_write}, 2'b11);
        tick(); #1;
        chk("r_decode_state", state_dbg, 4'd1);
        chk("r_decode_src", {alu_src_a, alu_src_b, alu_op}, 6'b01_01_00);
        tick(); #1;
        chk("r_exec_state", state_dbg, 4'd2);
        chk("r_exec_aluop", alu_op, 2'b10);
        chk("r_exec_wr_ret", {reg_write, instr_retired}, 2'b00);
        tick(); #1;
        chk("r_wb_state", state_dbg, 4'd8);
        chk("r_wb_wr_ret", {reg_write, instr_retired, result_src}, 4'b11_00);
        tick(); #1;
        chk("r_back_fetch", state_dbg, 4'd0);

        // LW with three wait cycles in MEM_READ: 0,1,4,5,5,5,5,6
        opcode = 7'b0000011;
        tick(); #1;
        chk("lw_decode", state_dbg, 4'd1);
        tick(); #1;
        chk("lw_addr_state", state_dbg, 4'd4);
        chk("lw_addr_src", {alu_src_a, alu_src_b, alu_op}, 6'b10_01_00);
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_ready = (i == 3);
            #1;
            chk("lw_read_state", state_dbg, 4'd5);
            chk("lw_read_req", {mem_req, mem_we, i_or_d}, 3'b101);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        chk("lw_wb_state", state_dbg, 4'd6);
        chk("lw_wb_ctl", {reg_write, result_src, instr_retired}, 4'b1_01_1);
        tick(); #1;
        chk("lw_back_fetch", state_dbg, 4'd0);

        // BEQ taken (zero=1)
        opcode = 7'b1100011;
        funct3 = 3'b000;
        zero   = 1'b1;
        tick(); #1;
        chk("beq_decode", state_dbg, 4'd1);
        tick(); #1;
        chk("beq_state", state_dbg, 4'd9);
        chk("beq_ctl", {pc_write, pc_src, alu_op, instr_retired}, 5'b1_1_01_1);
        tick(); #1;
        chk("beq_back_fetch", state_dbg, 4'd0);

        // BNE with zero=1: not taken
        funct3 = 3'b001;
        tick(); tick(); #1;
        chk("bne_state", state_dbg, 4'd9);
        chk("bne_nt_pcw", pc_write, 1'b0);
        zero = 1'b0;
        #1;
        chk("bne_t_pcw", pc_write, 1'b1);
        tick(); #1;
        chk("bne_back_fetch", state_dbg, 4'd0);

        // JAL: 0,1,10,8
        opcode = 7'b1101111;
        tick(); tick(); #1;
        chk("jal_state", state_dbg, 4'd10);
        chk("jal_ctl", {pc_write, pc_src, alu_src_a, alu_src_b, alu_op}, 8'b1_1_01_10_00);
        tick(); #1;
        chk("jal_wb", {state_dbg, reg_write, instr_retired}, 6'b1000_1_1);
        tick(); #1;
        chk("jal_back_fetch", state_dbg, 4'd0);

        // SW completing with mem_ready=1: 0,1,4,7
        opcode = 7'b0100011;
        tick(); tick(); #1;
        chk("sw_addr", state_dbg, 4'd4);
        tick(); #1;
        chk("sw_write_state", state_dbg, 4'd7);
        chk("sw_write_ctl", {mem_req, mem_we, i_or_d, instr_retired}, 4'b1111);
        tick(); #1;
        chk("sw_back_fetch", state_dbg, 4'd0);

        // Illegal opcode: sticky TRAP
        opcode = 7'b1111111;
        tick(); tick(); #1;
        for (int i = 0; i < 10; i++) begin
            chk("trap_state", state_dbg, 4'd11);
            chk("trap_illegal", {illegal_instr, mem_req}, 2'b10);
            tick(); #1;
        end
        rst = 1'b1;
        #1;
        chk("trap_rst_illegal", illegal_instr, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("trap_rst_fetch", state_dbg, 4'd0);

        // SW interrupted by rst during the MEM_WRITE wait
        opcode = 7'b0100011;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        chk("swr_wait_state", state_dbg, 4'd7);
        chk("swr_wait_ctl", {mem_req, mem_we, instr_retired}, 3'b110);
        tick(); #1;
        chk("swr_hold_state", state_dbg, 4'd7);
        rst = 1'b1;
        #1;
        chk("swr_rst_drop", {mem_req, mem_we, instr_retired}, 3'b000);
        tick();
        rst = 1'b0;
        #1;
        chk("swr_fetch_state", state_dbg, 4'd0);
        chk("swr_fetch_req", mem_req, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
